// File: rtl/qcm_gate_pkg.sv
// Shared gate definitions for the quantum control path: gate codes, the
// operand part of a gate-list entry, sequencer states and a count check.
package qcm_gate_pkg;

    typedef enum logic [2:0] {
        HADAMARD = 3'd0,
        PHASE    = 3'd1,
        CNOT     = 3'd2,
        MEASURE  = 3'd3,
        CPHASE   = 3'd4,
        TOFFOLI  = 3'd5
    } gate_code_t;

    // The phase index width is a per-instance parameter, so it is stored
    // alongside this struct rather than inside it.
    typedef struct packed {
        gate_code_t  gate_type;
        logic [31:0] qubit_pos;
        logic [31:0] qubit_pos2;
        logic [31:0] qubit_pos3;
    } gate_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic count_valid(input logic [31:0] n, input logic [31:0] max_n);
        return (n != 32'd0) && (n <= max_n);
    endfunction

endpackage

// File: rtl/gate_mem.sv
// Gate-list storage: one write port and one registered read port. A write and
// a read to the same entry on the same edge return the newly written word.
module gate_mem #(
    parameter  int max_gate = 64,
    parameter  int DATA_W   = 104,
    localparam int ADDR_W   = (max_gate > 1) ? $clog2(max_gate) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [max_gate];
    logic [DATA_W-1:0] r_rd_data;

    // Entry write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register, cleared by reset, with write-first bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= {DATA_W{1'b0}};
        end else if (i_rd_en) begin
            if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
                r_rd_data <= i_wr_data;
            end else begin
                r_rd_data <= r_mem[i_rd_addr];
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gate_sequencer.sv
// Gate sequencer: holds a loaded gate list and presents one entry at a time to
// the control unit, advancing on each update_gate_info pulse.
module gate_sequencer
    import qcm_gate_pkg::*;
#(
    parameter  int num_qubit    = 3,
    parameter  int phase_lookup = 5,
    parameter  int max_gate     = 64,
    localparam int ADDR_W       = (max_gate > 1) ? $clog2(max_gate) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_en,
    input  logic [ADDR_W-1:0]       load_addr,
    input  logic [2:0]              load_gate_type,
    input  logic [phase_lookup-1:0] load_phase_shift_index,
    input  logic [31:0]             load_qubit_pos,
    input  logic [31:0]             load_qubit_pos2,
    input  logic [31:0]             load_qubit_pos3,
    input  logic                    start,
    input  logic [31:0]             num_gate_in,
    input  logic                    update_gate_info,
    output logic [2:0]              gate_type,
    output logic [phase_lookup-1:0] phase_shift_index,
    output logic [31:0]             qubit_pos,
    output logic [31:0]             qubit_pos2,
    output logic [31:0]             qubit_pos3,
    output logic                    final_gate,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             gate_count,
    output logic                    err
);

    localparam int ENTRY_W = $bits(gate_entry_t) + phase_lookup;

    if ((num_qubit < 1) || (phase_lookup < 1) || (max_gate < 1)) begin : g_bad_param
        $error("gate_sequencer: invalid parameterisation");
    end

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [31:0]         r_num_gate;
    logic [31:0]         r_gate_count;
    logic                r_final_gate;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_stopped;
    logic                w_num_ok;
    logic                w_start_ok;
    logic                w_start_bad;
    logic                w_upd_run;
    logic                w_upd_bad;
    logic                w_ptr_adv;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    gate_entry_t         w_wr_entry;
    gate_entry_t         w_rd_entry;
    logic [phase_lookup-1:0] w_rd_phase;
    logic [ENTRY_W-1:0]  w_wr_word;
    logic [ENTRY_W-1:0]  w_rd_word;

    assign w_stopped   = (r_state != ST_RUN);
    assign w_num_ok    = count_valid(num_gate_in, 32'(max_gate));
    assign w_start_ok  = start & w_stopped & w_num_ok;
    assign w_start_bad = start & w_stopped & ~w_num_ok;
    assign w_upd_run   = update_gate_info & ~w_stopped;
    assign w_upd_bad   = update_gate_info & w_stopped;
    assign w_ptr_adv   = w_upd_run & ((32'(r_ptr) + 32'd1) < r_num_gate);
    assign w_wr_en     = load_en & w_stopped & ({1'b0, load_addr} < (ADDR_W + 1)'(max_gate));
    assign w_rd_en     = w_start_ok | w_upd_run;

    // Address of the entry to present after this edge.
    always_comb begin
        w_rd_addr = r_ptr;
        if (w_start_ok) begin
            w_rd_addr = {ADDR_W{1'b0}};
        end else if (w_ptr_adv) begin
            w_rd_addr = r_ptr + ADDR_W'(1);
        end else begin
            w_rd_addr = r_ptr;
        end
    end

    // Pack the load port into a memory word.
    always_comb begin
        w_wr_entry.gate_type  = gate_code_t'(load_gate_type);
        w_wr_entry.qubit_pos  = load_qubit_pos;
        w_wr_entry.qubit_pos2 = load_qubit_pos2;
        w_wr_entry.qubit_pos3 = load_qubit_pos3;
        w_wr_word             = {load_phase_shift_index, w_wr_entry};
    end

    gate_mem #(
        .max_gate (max_gate),
        .DATA_W   (ENTRY_W)
    ) u_gate_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (load_addr),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_word)
    );

    assign {w_rd_phase, w_rd_entry} = w_rd_word;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; RUN retires to DONE once every gate has been consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_gate_count == r_num_gate) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pointer, counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= {ADDR_W{1'b0}};
            r_num_gate   <= 32'd0;
            r_gate_count <= 32'd0;
            r_final_gate <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_RUN);
            r_done <= (w_state_nxt == ST_DONE);
            r_err  <= w_start_bad | w_upd_bad;
            if (w_start_ok) begin
                r_num_gate   <= num_gate_in;
                r_ptr        <= {ADDR_W{1'b0}};
                r_gate_count <= 32'd0;
                r_final_gate <= 1'b0;
            end else begin
                if (w_ptr_adv) begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
                if (w_upd_run && (r_gate_count < r_num_gate)) begin
                    r_gate_count <= r_gate_count + 32'd1;
                end
                if ((r_state == ST_RUN) && (w_state_nxt == ST_DONE)) begin
                    r_final_gate <= 1'b1;
                end
            end
        end
    end

    assign gate_type         = w_rd_entry.gate_type;
    assign phase_shift_index = w_rd_phase;
    assign qubit_pos         = w_rd_entry.qubit_pos;
    assign qubit_pos2        = w_rd_entry.qubit_pos2;
    assign qubit_pos3        = w_rd_entry.qubit_pos3;
    assign final_gate        = r_final_gate;
    assign busy              = r_busy;
    assign done              = r_done;
    assign gate_count        = r_gate_count;
    assign err               = r_err;

endmodule
